// File: rtl/vttx_al_if.sv
// ---------------------------------------------------------------------------
// vttx_al_if
//   Bundles the PROM readback byte stream and the auto-load burst outputs of
//   vttx_al_extractor.
//
//   Handshake semantics:
//     - rom_dv is a one-cycle valid with no ready. A byte is consumed on every
//       edge where rom_dv is high.
//     - al_vttx_regs is a write strobe with no ready. The auto-load FIFO takes
//       al_data on every edge where the strobe is high. A burst is N_REGS
//       consecutive strobes with no gaps.
//     - al_start is a one-cycle request. It is only honoured while the
//       extractor is idle.
//
//   Signals:
//     al_start      request a scan (pulse)
//     rom_data      PROM readback byte
//     rom_dv        rom_data valid
//     al_data       payload byte to auto-load FIFO (0 when no strobe)
//     al_vttx_regs  al_data write strobe
//     al_busy       scan/burst in progress
//     al_done       one-cycle pulse after the last strobe
//     al_err        00 ok, 01 not found/timeout, 10 bad count, 11 checksum
//
//   Modports:
//     master  stimulus side (drives the request and the byte stream)
//     slave   extractor side
// ---------------------------------------------------------------------------
interface vttx_al_if;
  logic       al_start;
  logic [7:0] rom_data;
  logic       rom_dv;
  logic [7:0] al_data;
  logic       al_vttx_regs;
  logic       al_busy;
  logic       al_done;
  logic [1:0] al_err;

  modport master (
    output al_start, rom_data, rom_dv,
    input  al_data, al_vttx_regs, al_busy, al_done, al_err
  );

  modport slave (
    input  al_start, rom_data, rom_dv,
    output al_data, al_vttx_regs, al_busy, al_done, al_err
  );
endinterface

// File: rtl/vttx_al_extractor.sv
// ---------------------------------------------------------------------------
// vttx_al_extractor
//   Scans the PROM readback byte stream for the VTTX register section
//   (MARKER, TAG, count, payload, XOR checksum). It buffers the payload and
//   checks the checksum. Only when the checksum matches does it burst the
//   payload out as N_REGS consecutive al_vttx_regs strobes.
//
//   Ports:
//     clk40_i      40 MHz system clock
//     rst_b_i      synchronous reset, active low
//     al_if        vttx_al_if.slave (stream in, burst/status out)
//     dbg_state_o  current FSM state, for observation only
// ---------------------------------------------------------------------------
module vttx_al_extractor #(
  parameter logic [7:0]  MARKER     = 8'hA5,
  parameter logic [7:0]  TAG        = 8'h5C,
  parameter int unsigned N_REGS     = 7,
  parameter int unsigned SCAN_LIMIT = 1024,
  parameter int unsigned TIMEOUT    = 4000
) (
  input  logic        clk40_i,
  input  logic        rst_b_i,
  vttx_al_if.slave    al_if,
  output logic [3:0]  dbg_state_o
);

  localparam int unsigned SCAN_W = $clog2(SCAN_LIMIT + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [SCAN_W-1:0] SCAN_MAX  = SCAN_W'(SCAN_LIMIT);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]        IDX_LAST  = 4'(N_REGS - 1);
  localparam logic [3:0]        IDX_END   = 4'(N_REGS);
  localparam logic [7:0]        CNT_BYTE  = 8'(N_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_HUNT, S_TAGCHK, S_COUNT, S_DATA, S_CKSUM, S_BURST, S_DONE, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [SCAN_W-1:0]  scan_q, scan_d, scan_inc;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         xor_q, xor_d;
  // 16 entries so the 4-bit index always addresses a real slot; only
  // entries 0..N_REGS-1 are ever written or read.
  logic [7:0]         pl_buf_q [16];
  logic [7:0]         pl_buf_d [16];
  logic [7:0]         data_q, data_d;
  logic               strobe_q, strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               fail;
  logic [1:0]         fail_code;

  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    tmo_d     = tmo_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    pl_buf_d  = pl_buf_q;
    data_d    = data_q;
    strobe_d  = strobe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    fail      = 1'b0;
    fail_code = 2'b00;
    scan_inc  = scan_q + SCAN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (al_if.al_start) begin
          state_d = S_HUNT;
          busy_d  = 1'b1;
          err_d   = 2'b00;
          scan_d  = '0;
          tmo_d   = '0;
        end
      end

      S_HUNT, S_TAGCHK, S_COUNT, S_DATA, S_CKSUM: begin
        // A byte arriving in the same cycle the timeout would expire wins:
        // the timeout branch is only taken when no byte is present.
        if (al_if.rom_dv) begin
          tmo_d = '0;
          case (state_q)
            S_HUNT: begin
              scan_d = scan_inc;
              if (al_if.rom_data == MARKER) state_d = S_TAGCHK;
            end
            S_TAGCHK: begin
              scan_d = scan_inc;
              if (al_if.rom_data == TAG)         state_d = S_COUNT;
              else if (al_if.rom_data != MARKER) state_d = S_HUNT;
            end
            S_COUNT: begin
              if (al_if.rom_data == CNT_BYTE) begin
                state_d = S_DATA;
                idx_d   = '0;
                xor_d   = '0;
              end else begin
                fail      = 1'b1;
                fail_code = 2'b10;
              end
            end
            S_DATA: begin
              pl_buf_d[idx_q] = al_if.rom_data;
              xor_d           = xor_q ^ al_if.rom_data;
              idx_d           = idx_q + 4'd1;
              if (idx_q == IDX_LAST) state_d = S_CKSUM;
            end
            S_CKSUM: begin
              if (al_if.rom_data == xor_q) begin
                // First burst byte is registered here so the strobe rises
                // the cycle right after the checksum byte.
                state_d  = S_BURST;
                strobe_d = 1'b1;
                data_d   = pl_buf_q[0];
                idx_d    = 4'd1;
              end else begin
                fail      = 1'b1;
                fail_code = 2'b11;
              end
            end
            default: ;
          endcase
          // The scan limit only applies while still hunting. A tag match on
          // the last allowed byte still proceeds to COUNT.
          if ((state_d == S_HUNT || state_d == S_TAGCHK) && scan_inc == SCAN_MAX) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end
        end else if (tmo_q == TMO_LAST) begin
          fail      = 1'b1;
          fail_code = 2'b01;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_BURST: begin
        if (idx_q == IDX_END) begin
          state_d  = S_DONE;
          strobe_d = 1'b0;
          data_d   = 8'h00;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          data_d = pl_buf_q[idx_q];
          idx_d  = idx_q + 4'd1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      state_d = S_ERR;
      err_d   = fail_code;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk40_i) begin
    if (!rst_b_i) begin
      state_q  <= S_IDLE;
      scan_q   <= '0;
      tmo_q    <= '0;
      idx_q    <= '0;
      xor_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 2'b00;
      for (int i = 0; i < 16; i++) pl_buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      scan_q   <= scan_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pl_buf_q <= pl_buf_d;
    end
  end

  assign al_if.al_data      = data_q;
  assign al_if.al_vttx_regs = strobe_q;
  assign al_if.al_busy      = busy_q;
  assign al_if.al_done      = done_q;
  assign al_if.al_err       = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_vttx_al_extractor.sv
// ---------------------------------------------------------------------------
// tb_vttx_al_extractor
//   Directed bench for vttx_al_extractor. Each run pushes its expected burst
//   bytes into exp_q when the stimulus is issued. A negedge monitor pops and
//   compares on every al_vttx_regs strobe, and each run ends with status
//   checks.
// ---------------------------------------------------------------------------
module tb_vttx_al_extractor;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] dbg_state;

  vttx_al_if bus();

  vttx_al_extractor dut (
    .clk40_i    (clk),
    .rst_b_i    (rst_b),
    .al_if      (bus),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus data ----------------
  // Payload of the VTTX section.
  // XOR checksum by hand: 87^99=1E, ^19=07, ^88=8F, ^FF=70, ^FF=8F, ^04=8B.
  logic [7:0] payload [7] = '{8'h87, 8'h99, 8'h19, 8'h88, 8'hFF, 8'hFF, 8'h04};
  localparam logic [7:0] GOOD_CK = 8'h8B;
  localparam logic [7:0] BAD_CK  = 8'h8A;

  logic [7:0] exp_q  [$];
  logic [7:0] stim_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- monitor state ----------------
  int n_strobe, n_done, first_cyc, cks_cyc, dv_cyc;
  bit leak, gap_bad, done_bad, prev_strobe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst_b) begin
      if (bus.al_vttx_regs) begin
        if (!prev_strobe) begin
          if (n_strobe != 0) gap_bad = 1'b1;
          first_cyc = cyc;
          cks_cyc   = dv_cyc;
        end
        n_strobe++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL burst_byte: unexpected strobe with data %02h, required no strobe", bus.al_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("burst_byte", 32'(bus.al_data), 32'(exp_b));
        end
      end else if (bus.al_data != 8'h00) begin
        leak = 1'b1;
      end
      if (bus.al_done) begin
        n_done++;
        if (!prev_strobe || bus.al_busy) done_bad = 1'b1;
      end
      if (bus.rom_dv) dv_cyc = cyc + 1;
      prev_strobe = bus.al_vttx_regs;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    n_strobe  = 0;
    n_done    = 0;
    leak      = 1'b0;
    gap_bad   = 1'b0;
    done_bad  = 1'b0;
    first_cyc = -1;
    cks_cyc   = -2;
    exp_q.delete();
  endtask

  // All driver tasks enter and leave at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bus.rom_dv   = 1'b1;
    bus.rom_data = b;
    @(posedge clk); #1;
    bus.rom_dv   = 1'b0;
    bus.rom_data = 8'h00;
  endtask

  task automatic send_stim();
    while (stim_q.size() > 0) send_byte(stim_q.pop_front());
  endtask

  task automatic push_frame(input logic [7:0] cnt, input logic [7:0] ck);
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h5C);
    stim_q.push_back(cnt);
    foreach (payload[i]) stim_q.push_back(payload[i]);
    stim_q.push_back(ck);
  endtask

  task automatic begin_run(input string name, input bit expect_burst);
    clear_mon();
    if (expect_burst) foreach (payload[i]) exp_q.push_back(payload[i]);
    bus.al_start = 1'b1;
    @(posedge clk); #1;
    bus.al_start = 1'b0;
    check({name, "_busy_rise"}, 32'(bus.al_busy), 32'd1);
    check({name, "_err_clr"},   32'(bus.al_err),  32'd0);
  endtask

  task automatic finish_run(input string name, input bit expect_burst, input logic [1:0] exp_err);
    for (int i = 0; i < 200; i++) begin
      if (!bus.al_busy) break;
      @(posedge clk); #1;
    end
    check({name, "_busy_fall"}, 32'(bus.al_busy), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check({name, "_err"},        32'(bus.al_err),  32'(exp_err));
    check({name, "_strobes"},    32'(n_strobe),    expect_burst ? 32'd7 : 32'd0);
    check({name, "_done_cnt"},   32'(n_done),      expect_burst ? 32'd1 : 32'd0);
    check({name, "_exp_left"},   32'(exp_q.size()), 32'd0);
    check({name, "_data_leak"},  32'(leak),        32'd0);
    check({name, "_gap"},        32'(gap_bad),     32'd0);
    check({name, "_done_align"}, 32'(done_bad),    32'd0);
    check({name, "_idle_busy"},  32'(bus.al_busy), 32'd0);
    if (expect_burst) check({name, "_burst_start"}, 32'(first_cyc), 32'(cks_cyc));
    exp_q.delete();
  endtask

  // Waits (bounded) until the n-th strobe cycle is in progress.
  task automatic wait_strobes(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < 20 && seen < n; i++) begin
      if (bus.al_vttx_regs) seen++;
      if (seen < n) begin @(posedge clk); #1; end
    end
    check({name, "_strobe_reach"}, 32'(seen), 32'(n));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_b        = 1'b0;
    bus.al_start = 1'b0;
    bus.rom_dv   = 1'b0;
    bus.rom_data = 8'h00;
    clear_mon();
    dv_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",   32'(bus.al_data),      32'd0);
    check("rst_strobe", 32'(bus.al_vttx_regs), 32'd0);
    check("rst_busy",   32'(bus.al_busy),      32'd0);
    check("rst_done",   32'(bus.al_done),      32'd0);
    check("rst_err",    32'(bus.al_err),       32'd0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Good frame behind a leading junk byte.
    stim_q.push_back(8'h00);
    push_frame(8'h07, GOOD_CK);
    begin_run("t1_good", 1'b1);
    send_stim();
    finish_run("t1_good", 1'b1, 2'b00);

    // Immediate repeat produces an identical burst.
    stim_q.push_back(8'h00);
    push_frame(8'h07, GOOD_CK);
    begin_run("t6_repeat", 1'b1);
    send_stim();
    finish_run("t6_repeat", 1'b1, 2'b00);

    // Bad checksum: no strobe at all.
    stim_q.push_back(8'h00);
    push_frame(8'h07, BAD_CK);
    begin_run("t2_badck", 1'b0);
    send_stim();
    finish_run("t2_badck", 1'b0, 2'b11);

    // Double marker; also clears the previous checksum error on start.
    stim_q.push_back(8'hA5);
    push_frame(8'h07, GOOD_CK);
    begin_run("t3_dblmark", 1'b1);
    send_stim();
    finish_run("t3_dblmark", 1'b1, 2'b00);

    // Marker followed by a non-tag byte, then a real section.
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h33);
    push_frame(8'h07, GOOD_CK);
    begin_run("t3_resync", 1'b1);
    send_stim();
    finish_run("t3_resync", 1'b1, 2'b00);

    // Wrong count byte.
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h5C);
    stim_q.push_back(8'h06);
    begin_run("t4_badcnt", 1'b0);
    send_stim();
    finish_run("t4_badcnt", 1'b0, 2'b10);

    // Scan limit: 1023 non-marker bytes keep hunting; the 1024th ends it.
    begin_run("t4_scan", 1'b0);
    repeat (1023) send_byte(8'h00);
    check("t4_scan_1023_busy", 32'(bus.al_busy), 32'd1);
    send_byte(8'h00);
    check("t4_scan_1024_busy", 32'(bus.al_busy), 32'd0);
    check("t4_scan_1024_err",  32'(bus.al_err),  32'd1);
    finish_run("t4_scan", 1'b0, 2'b01);

    // Stall inside the payload: 3999 idle cycles tolerated, the 4000th expires.
    begin_run("t4_tmo", 1'b0);
    send_byte(8'hA5);
    send_byte(8'h5C);
    send_byte(8'h07);
    repeat (3999) begin @(posedge clk); #1; end
    check("t4_tmo_3999_busy", 32'(bus.al_busy), 32'd1);
    @(posedge clk); #1;
    check("t4_tmo_4000_busy", 32'(bus.al_busy), 32'd0);
    check("t4_tmo_4000_err",  32'(bus.al_err),  32'd1);
    finish_run("t4_tmo", 1'b0, 2'b01);

    // AL_START plus a stray ROM byte during the burst: both ignored.
    push_frame(8'h07, GOOD_CK);
    begin_run("t5_start_burst", 1'b1);
    send_stim();
    wait_strobes("t5_start_burst", 2);
    bus.al_start = 1'b1;
    bus.rom_dv   = 1'b1;
    bus.rom_data = 8'hA5;
    @(posedge clk); #1;
    bus.al_start = 1'b0;
    bus.rom_dv   = 1'b0;
    bus.rom_data = 8'h00;
    finish_run("t5_start_burst", 1'b1, 2'b00);

    // Reset asserted during the third strobe.
    push_frame(8'h07, GOOD_CK);
    begin_run("t5_rst_burst", 1'b1);
    send_stim();
    wait_strobes("t5_rst_burst", 3);
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_data",   32'(bus.al_data),      32'd0);
    check("t5_rst_strobe", 32'(bus.al_vttx_regs), 32'd0);
    check("t5_rst_busy",   32'(bus.al_busy),      32'd0);
    check("t5_rst_done",   32'(bus.al_done),      32'd0);
    check("t5_rst_err",    32'(bus.al_err),       32'd0);
    rst_b = 1'b1;
    clear_mon();
    @(posedge clk); #1;

    // Full run after the mid-burst reset.
    push_frame(8'h07, GOOD_CK);
    begin_run("t6_after_rst", 1'b1);
    send_stim();
    finish_run("t6_after_rst", 1'b1, 2'b00);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
